cpr_freq_meter: RTL and testbench

Measures the frequency of the four divided critical-path-replica clocks LOGICCPR_1..LOGICCPR_4 by counting their rising edges over a programmable window of system-clock cycles. It sits directly downstream of the CPR ring-oscillator/divider stage. It delivers per-channel edge counts, a completion pulse and a below-threshold alarm to the power-management controller, which uses them to adjust body-bias and voltage.

---
 rtl/cpr_freq_meter_if.sv | 46 ++++
 rtl/cpr_freq_meter.sv | 203 ++++++++++++++++++++
 tb/tb_cpr_freq_meter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpr_freq_meter_if.sv
// Control/result bundle between the power-management controller (master)
// and the CPR frequency meter (slave).
// CPR_METER_MINMAX_EN adds the CLR_MIN input and the MIN_1..MIN_4 outputs.
interface cpr_freq_meter_if #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 16
);
   logic             START;
   logic             ABORT;
   logic [WIN_W-1:0] WINDOW;
   logic [CNT_W-1:0] THRESH;
   logic             BUSY;
   logic             VALID;
   logic [CNT_W-1:0] COUNT_1;
   logic [CNT_W-1:0] COUNT_2;
   logic [CNT_W-1:0] COUNT_3;
   logic [CNT_W-1:0] COUNT_4;
   logic [3:0]       ALARM;
`ifdef CPR_METER_MINMAX_EN
   logic             CLR_MIN;
   logic [CNT_W-1:0] MIN_1;
   logic [CNT_W-1:0] MIN_2;
   logic [CNT_W-1:0] MIN_3;
   logic [CNT_W-1:0] MIN_4;

   modport master (
      output START, ABORT, WINDOW, THRESH, CLR_MIN,
      input  BUSY, VALID, COUNT_1, COUNT_2, COUNT_3, COUNT_4, ALARM,
             MIN_1, MIN_2, MIN_3, MIN_4
   );
   modport slave (
      input  START, ABORT, WINDOW, THRESH, CLR_MIN,
      output BUSY, VALID, COUNT_1, COUNT_2, COUNT_3, COUNT_4, ALARM,
             MIN_1, MIN_2, MIN_3, MIN_4
   );
`else
   modport master (
      output START, ABORT, WINDOW, THRESH,
      input  BUSY, VALID, COUNT_1, COUNT_2, COUNT_3, COUNT_4, ALARM
   );
   modport slave (
      input  START, ABORT, WINDOW, THRESH,
      output BUSY, VALID, COUNT_1, COUNT_2, COUNT_3, COUNT_4, ALARM
   );
`endif
endinterface

// File: rtl/cpr_freq_meter.sv
// CPR frequency meter: counts rising edges of four asynchronous divided
// critical-path-replica clocks over a programmable window of CLK cycles.
// Optional feature macro: CPR_METER_MINMAX_EN (running per-channel minimum).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for START; counters hold, results held
// ST_SETTLE  | 3 cycles flushing stale synchronizer history, no counting
// ST_MEASURE | latched-window cycles, counting detected rising edges
module cpr_freq_meter #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 16
) (
   input  logic              CLK,
   input  logic              RN,
   input  logic              LOGICCPR_1,
   input  logic              LOGICCPR_2,
   input  logic              LOGICCPR_3,
   input  logic              LOGICCPR_4,
   cpr_freq_meter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
   localparam logic [WIN_W-1:0] SETTLE_TC = WIN_W'(2);

   logic [3:0] s1_q, s2_q, s3_q;
   logic [3:0] s1_d, s2_d, s3_d;
   logic [3:0] rise;

   state_t           state_q, state_d;
   logic [WIN_W-1:0] tmr_q, tmr_d;
   logic [WIN_W-1:0] win_m1_q, win_m1_d;
   logic [CNT_W-1:0] thresh_q, thresh_d;
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_d   [4];
   logic [CNT_W-1:0] cnt_inc [4];
   logic [CNT_W-1:0] count_q [4];
   logic [CNT_W-1:0] count_d [4];
   logic [3:0]       alarm_q, alarm_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             meas_done;

   // Synchronizer chain inputs: two flops for metastability plus a history flop
   always_comb begin
      s1_d = {LOGICCPR_4, LOGICCPR_3, LOGICCPR_2, LOGICCPR_1};
      s2_d = s1_q;
      s3_d = s2_q;
   end

   assign rise = s2_q & ~s3_q;

   // Synchronizers run continuously, independent of the FSM
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   // Saturating increment of each edge counter
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_inc[i] = (rise[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_ONE : cnt_q[i];
      end
   end

   // Next-state, timer and result logic; ABORT overrides every busy transition
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      win_m1_d  = win_m1_q;
      thresh_d  = thresh_q;
      cnt_d     = cnt_q;
      count_d   = count_q;
      alarm_d   = alarm_q;
      valid_d   = 1'b0;
      meas_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.START && !bus.ABORT) begin
               state_d  = ST_SETTLE;
               tmr_d    = SETTLE_TC;
               // A zero window behaves as a one-cycle window
               win_m1_d = (bus.WINDOW == '0) ? '0 : bus.WINDOW - WIN_ONE;
               thresh_d = bus.THRESH;
               for (int i = 0; i < 4; i++) cnt_d[i] = '0;
            end
         end
         ST_SETTLE: begin
            if (bus.ABORT) begin
               state_d = ST_IDLE;
            end else if (tmr_q == '0) begin
               state_d = ST_MEASURE;
               tmr_d   = win_m1_q;
            end else begin
               tmr_d = tmr_q - WIN_ONE;
            end
         end
         ST_MEASURE: begin
            if (bus.ABORT) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (tmr_q == '0) begin
                  state_d   = ST_IDLE;
                  meas_done = 1'b1;
                  valid_d   = 1'b1;
                  count_d   = cnt_inc;
                  for (int i = 0; i < 4; i++) alarm_d[i] = (cnt_inc[i] < thresh_q);
               end else begin
                  tmr_d = tmr_q - WIN_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // FSM, timer, counters and registered outputs
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q  <= ST_IDLE;
         tmr_q    <= '0;
         win_m1_q <= '0;
         thresh_q <= '0;
         alarm_q  <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i]   <= '0;
            count_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         win_m1_q <= win_m1_d;
         thresh_q <= thresh_d;
         alarm_q  <= alarm_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i]   <= cnt_d[i];
            count_q[i] <= count_d[i];
         end
      end
   end

   assign bus.BUSY    = busy_q;
   assign bus.VALID   = valid_q;
   assign bus.COUNT_1 = count_q[0];
   assign bus.COUNT_2 = count_q[1];
   assign bus.COUNT_3 = count_q[2];
   assign bus.COUNT_4 = count_q[3];
   assign bus.ALARM   = alarm_q;

`ifdef CPR_METER_MINMAX_EN
   logic [CNT_W-1:0] min_q [4];
   logic [CNT_W-1:0] min_d [4];

   // Running minimum updates together with COUNT; a clear landing on the
   // same edge as a new result restarts the minimum from that result
   always_comb begin
      min_d = min_q;
      for (int i = 0; i < 4; i++) begin
         if (meas_done) begin
            if (bus.CLR_MIN || (cnt_inc[i] < min_q[i])) min_d[i] = cnt_inc[i];
         end else if (bus.CLR_MIN) begin
            min_d[i] = CNT_MAX;
         end
      end
   end

   // Minimum registers reset to all-ones
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         for (int i = 0; i < 4; i++) min_q[i] <= CNT_MAX;
      end else begin
         for (int i = 0; i < 4; i++) min_q[i] <= min_d[i];
      end
   end

   assign bus.MIN_1 = min_q[0];
   assign bus.MIN_2 = min_q[1];
   assign bus.MIN_3 = min_q[2];
   assign bus.MIN_4 = min_q[3];
`endif

endmodule

// File: tb/tb_cpr_freq_meter.sv
// Self-checking bench for cpr_freq_meter. CPR inputs are periodic square
// waves whose period divides the window, so the edge count is exactly
// window/period (saturated to the counter width).
`timescale 1ns/1ps
module tb_cpr_freq_meter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          per [4] = '{10, 4, 20, 50};
   int          ph  [4] = '{0, 1, 2, 3};
   logic [3:0]  cpr = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] window = '0;
   logic [15:0] thresh = '0;
   logic [15:0] prev_cnt [4];
   logic [3:0]  prev_alarm;
   int          div60 [10] = '{3, 4, 5, 6, 10, 12, 15, 20, 30, 60};
`ifdef CPR_METER_MINMAX_EN
   logic        clr_min = 1'b0;
`endif

   cpr_freq_meter_if #(.CNT_W(16), .WIN_W(16)) bus_a ();
   cpr_freq_meter_if #(.CNT_W(4),  .WIN_W(16)) bus_s ();

   assign bus_a.START  = start;
   assign bus_a.ABORT  = abort;
   assign bus_a.WINDOW = window;
   assign bus_a.THRESH = thresh;
   assign bus_s.START  = start;
   assign bus_s.ABORT  = abort;
   assign bus_s.WINDOW = window;
   assign bus_s.THRESH = thresh[3:0];
`ifdef CPR_METER_MINMAX_EN
   assign bus_a.CLR_MIN = clr_min;
   assign bus_s.CLR_MIN = clr_min;
`endif

   cpr_freq_meter #(.CNT_W(16), .WIN_W(16)) dut (
      .CLK(clk), .RN(rst_n),
      .LOGICCPR_1(cpr[0]), .LOGICCPR_2(cpr[1]), .LOGICCPR_3(cpr[2]), .LOGICCPR_4(cpr[3]),
      .bus(bus_a)
   );

   cpr_freq_meter #(.CNT_W(4), .WIN_W(16)) dut_sat (
      .CLK(clk), .RN(rst_n),
      .LOGICCPR_1(cpr[0]), .LOGICCPR_2(cpr[1]), .LOGICCPR_3(cpr[2]), .LOGICCPR_4(cpr[3]),
      .bus(bus_s)
   );

   // Square-wave generators: high for per/2 cycles, low for the rest
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         ph[i]  = (ph[i] + 1) % per[i];
         cpr[i] = (ph[i] < per[i] / 2);
      end
   end

   function automatic logic [15:0] exp_cnt(input int w, input int p, input int maxv);
      int c;
      c = ((w == 0) ? 1 : w) / p;
      return (c > maxv) ? maxv[15:0] : c[15:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One measurement from a START issued in the current cycle.
   task automatic run_meas(input int w, input logic [15:0] th, input bit chk_cnt, input bit poke_start);
      int          weff, cyc;
      bit          got, b1, bend;
      logic [15:0] obs [4];
      logic [15:0] e;
      logic [3:0]  ea;
      weff = (w == 0) ? 1 : w;
      start = 1'b1; window = w[15:0]; thresh = th;
      cyc = 0; got = 0; b1 = 0; bend = 0;
      while (!got && cyc < weff + 20) begin
         step(1);
         start = 1'b0;
         cyc++;
         if (poke_start && cyc == 2) begin
            start = 1'b1; window = 16'd7; thresh = 16'hFFFF;
         end
         if (cyc == 1) b1 = bus_a.BUSY;
         if (cyc == weff + 3) bend = bus_a.BUSY;
         if (bus_a.VALID) got = 1;
      end
      check("valid_seen", 32'(got), 32'd1);
      check("valid_cycle", 32'(cyc), 32'(weff + 4));
      check("busy_first", 32'(b1), 32'd1);
      check("busy_last", 32'(bend), 32'd1);
      check("busy_at_valid", 32'(bus_a.BUSY), 32'd0);
      if (chk_cnt) begin
         obs[0] = bus_a.COUNT_1; obs[1] = bus_a.COUNT_2;
         obs[2] = bus_a.COUNT_3; obs[3] = bus_a.COUNT_4;
         ea = '0;
         for (int i = 0; i < 4; i++) begin
            e = exp_cnt(w, per[i], 65535);
            check($sformatf("count_%0d", i + 1), 32'(obs[i]), 32'(e));
            ea[i] = (e < th);
            prev_cnt[i] = e;
         end
         check("alarm", 32'(bus_a.ALARM), 32'(ea));
         prev_alarm = ea;
         check("sat_count_1", 32'(bus_s.COUNT_1), 32'(exp_cnt(w, per[0], 15)));
      end
   endtask

   initial begin
      int vcount, k, w;
      logic [15:0] th;

      // Reset state
      step(3);
      check("rst_busy", 32'(bus_a.BUSY), 0);
      check("rst_valid", 32'(bus_a.VALID), 0);
      check("rst_count_1", 32'(bus_a.COUNT_1), 0);
      check("rst_count_4", 32'(bus_a.COUNT_4), 0);
      check("rst_alarm", 32'(bus_a.ALARM), 0);
      rst_n = 1'b1;
      step(5);

      // Basic count, periods 10/4/20/50, window 100, threshold 10
      run_meas(100, 16'd10, 1, 0);
      // START in the VALID cycle: back-to-back run
      run_meas(100, 16'd10, 1, 0);
      step(1);
      check("valid_one_cycle", 32'(bus_a.VALID), 0);

      // START while busy is ignored; changed WINDOW/THRESH have no effect
      step(2);
      run_meas(200, 16'd30, 1, 1);
      step(3);
      check("busy_after_poke", 32'(bus_a.BUSY), 0);

      // ABORT mid-measure
      start = 1'b1; window = 16'd100; thresh = 16'd0;
      step(1);
      start = 1'b0;
      step(49);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("abort_busy", 32'(bus_a.BUSY), 0);
      vcount = 0;
      for (int i = 0; i < 120; i++) begin
         if (bus_a.VALID) vcount++;
         step(1);
      end
      check("abort_no_valid", 32'(vcount), 0);
      check("abort_count_1", 32'(bus_a.COUNT_1), 32'(prev_cnt[0]));
      check("abort_count_2", 32'(bus_a.COUNT_2), 32'(prev_cnt[1]));
      check("abort_count_3", 32'(bus_a.COUNT_3), 32'(prev_cnt[2]));
      check("abort_count_4", 32'(bus_a.COUNT_4), 32'(prev_cnt[3]));
      check("abort_alarm", 32'(bus_a.ALARM), 32'(prev_alarm));

      // START together with ABORT in IDLE
      start = 1'b1; abort = 1'b1; window = 16'd10;
      step(1);
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle", 32'(bus_a.BUSY), 0);
      step(2);
      check("start_abort_idle2", 32'(bus_a.BUSY), 0);

      // Window 0 behaves as 1
      run_meas(0, 16'd0, 0, 0);
      step(1);
      check("w0_valid_pulse", 32'(bus_a.VALID), 0);

      // Randomized periods, windows and thresholds
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) per[i] = div60[$urandom_range(0, 9)];
         k  = $urandom_range(1, 4);
         w  = 60 * k;
         th = 16'($urandom_range(0, 30));
         step(5);
         run_meas(w, th, 1, 0);
      end

      // Reset mid-measure
      per = '{10, 4, 20, 50};
      step(5);
      start = 1'b1; window = 16'd100; thresh = 16'hFFFF;
      step(1);
      start = 1'b0;
      step(49);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus_a.BUSY), 0);
      check("mid_rst_valid", 32'(bus_a.VALID), 0);
      check("mid_rst_count_2", 32'(bus_a.COUNT_2), 0);
      check("mid_rst_alarm", 32'(bus_a.ALARM), 0);
`ifdef CPR_METER_MINMAX_EN
      check("mid_rst_min_1", 32'(bus_a.MIN_1), 32'hFFFF);
`endif
      step(1);
      rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 120; i++) begin
         if (bus_a.VALID) vcount++;
         step(1);
      end
      check("rst_no_valid", 32'(vcount), 0);
      check("rst_idle", 32'(bus_a.BUSY), 0);

`ifdef CPR_METER_MINMAX_EN
      per = '{4, 4, 4, 4};
      step(5);
      run_meas(100, 16'd0, 1, 0);
      check("min_1_first", 32'(bus_a.MIN_1), 32'd25);
      per = '{10, 10, 10, 10};
      step(5);
      run_meas(100, 16'd0, 1, 0);
      check("min_1_second", 32'(bus_a.MIN_1), 32'd10);
      step(2);
      clr_min = 1'b1;
      step(1);
      clr_min = 1'b0;
      check("min_1_clr", 32'(bus_a.MIN_1), 32'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
